reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_cell.sv | 34 +++
 rtl/reg_file.sv | 90 +++++++++
 tb/tb_reg_file.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file and its storage cells.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 16;

  // Index width for a bank of 'depth' registers; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_cell.sv
// One storage word of the register file: loads d on a qualified write edge.
module reg_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeEnable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (writeEnable) begin
      q_d = d;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reg_file.sv
// Parameterised register file: one write port, two registered read ports with
// optional same-cycle write forwarding and an optional hard-wired zero register.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeEnable,
  input  logic [AW-1:0]    writeAddr,
  input  logic [WIDTH-1:0] writeData,
  input  logic             readEnable,
  input  logic [AW-1:0]    readAddrA,
  input  logic [AW-1:0]    readAddrB,
  output logic [WIDTH-1:0] readA,
  output logic [WIDTH-1:0] readB,
  output logic             readValid
);

  logic [WIDTH-1:0] cell_q_s [DEPTH];
  logic [WIDTH-1:0] read_a_d;
  logic [WIDTH-1:0] read_b_d;
  logic [WIDTH-1:0] read_a_q;
  logic [WIDTH-1:0] read_b_q;
  logic             read_valid_d;
  logic             read_valid_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic cell_we_s;
    // Register 0 never sees a write strobe when it is the constant-zero register.
    assign cell_we_s = writeEnable && (writeAddr == AW'(i)) && !((ZERO_REG != 0) && (i == 0));

    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk         (clk),
      .reset       (reset),
      .writeEnable (cell_we_s),
      .d           (writeData),
      .q           (cell_q_s[i])
    );
  end

  always_comb begin
    read_a_d = read_a_q;
    if ((ZERO_REG != 0) && (readAddrA == '0)) begin
      read_a_d = '0;
    end else if ((BYPASS != 0) && writeEnable && (writeAddr == readAddrA)) begin
      read_a_d = writeData;
    end else begin
      read_a_d = cell_q_s[readAddrA];
    end
  end

  always_comb begin
    read_b_d = read_b_q;
    if ((ZERO_REG != 0) && (readAddrB == '0)) begin
      read_b_d = '0;
    end else if ((BYPASS != 0) && writeEnable && (writeAddr == readAddrB)) begin
      read_b_d = writeData;
    end else begin
      read_b_d = cell_q_s[readAddrB];
    end
  end

  assign read_valid_d = readEnable;

  // Read data is captured only on an accepted read and otherwise held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_a_q     <= '0;
      read_b_q     <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= read_valid_d;
      if (readEnable) begin
        read_a_q <= read_a_d;
        read_b_q <= read_b_d;
      end
    end
  end

  assign readA     = read_a_q;
  assign readB     = read_b_q;
  assign readValid = read_valid_q;

endmodule

// File: tb/tb_reg_file.sv
// Drives a default register file and a 32x8, no-zero-reg, no-bypass variant in
// lockstep, comparing both against an array-based reference of the read/write rules.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] wd;
  logic        re;
  logic [3:0]  wa0, ra0, rb0;
  logic [2:0]  wa1, ra1, rb1;
  logic [15:0] r0a, r0b;
  logic [31:0] r1a, r1b;
  logic        r0v, r1v;

  logic [15:0] m0 [16];
  logic [31:0] m1 [8];
  logic [15:0] e0a, e0b;
  logic [31:0] e1a, e1b;
  logic        e0v, e1v;

  int checks;
  int failures;

  reg_file u_dut0 (
    .clk(clk), .reset(reset), .writeEnable(we), .writeAddr(wa0), .writeData(wd[15:0]),
    .readEnable(re), .readAddrA(ra0), .readAddrB(rb0),
    .readA(r0a), .readB(r0b), .readValid(r0v)
  );

  reg_file #(.WIDTH(32), .DEPTH(8), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .reset(reset), .writeEnable(we), .writeAddr(wa1), .writeData(wd),
    .readEnable(re), .readAddrA(ra1), .readAddrB(rb1),
    .readA(r1a), .readB(r1b), .readValid(r1v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m0[i] = 16'h0000;
    for (int i = 0; i < 8; i++) m1[i] = 32'h0000_0000;
    e0a = 16'h0000; e0b = 16'h0000; e0v = 1'b0;
    e1a = 32'h0000_0000; e1b = 32'h0000_0000; e1v = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_d0_a"}, {16'h0000, r0a}, {16'h0000, e0a});
    check_eq({tag, "_d0_b"}, {16'h0000, r0b}, {16'h0000, e0b});
    check_eq({tag, "_d0_v"}, {31'h0, r0v}, {31'h0, e0v});
    check_eq({tag, "_d1_a"}, r1a, e1a);
    check_eq({tag, "_d1_b"}, r1b, e1b);
    check_eq({tag, "_d1_v"}, {31'h0, r1v}, {31'h0, e1v});
  endtask

  // One clock: apply a write and/or read, advance the reference, compare.
  task automatic step(input string tag, input logic w_en, input int w_a, input logic [31:0] w_d,
                      input logic r_en, input int a, input int b);
    we = w_en; wd = w_d; re = r_en;
    wa0 = 4'(w_a); ra0 = 4'(a); rb0 = 4'(b);
    wa1 = 3'(w_a); ra1 = 3'(a); rb1 = 3'(b);
    @(posedge clk); #1;
    if (r_en) begin
      // Default instance: r0 is constant zero, a same-address write is forwarded.
      e0a = (a % 16 == 0) ? 16'h0000 : (w_en && (w_a % 16 == a % 16)) ? w_d[15:0] : m0[a % 16];
      e0b = (b % 16 == 0) ? 16'h0000 : (w_en && (w_a % 16 == b % 16)) ? w_d[15:0] : m0[b % 16];
      // Variant: plain storage, reads see contents from before this edge's write.
      e1a = m1[a % 8];
      e1b = m1[b % 8];
    end
    e0v = r_en;
    e1v = r_en;
    if (w_en && (w_a % 16 != 0)) m0[w_a % 16] = w_d[15:0];
    if (w_en) m1[w_a % 8] = w_d;
    check_all(tag);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; we = 1'b0; wd = 32'h0; re = 1'b0;
    wa0 = 4'h0; ra0 = 4'h0; rb0 = 4'h0; wa1 = 3'h0; ra1 = 3'h0; rb1 = 3'h0;
    clear_model();
    #1;
    check_all("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic write then read, plus the wide variant.
    step("wr5", 1'b1, 5, 32'h0000_BEEF, 1'b0, 0, 0);
    step("rd5", 1'b0, 0, 32'h0, 1'b1, 5, 0);
    check_eq("basic_a", {16'h0000, r0a}, 32'h0000_BEEF);
    check_eq("basic_b", {16'h0000, r0b}, 32'h0000_0000);
    check_eq("basic_v", {31'h0, r0v}, 32'h1);
    step("wr7", 1'b1, 7, 32'hDEAD_BEEF, 1'b0, 0, 0);
    step("rd7", 1'b0, 0, 32'h0, 1'b1, 7, 7);
    check_eq("wide_a", r1a, 32'hDEAD_BEEF);

    // Read-during-write on the same address.
    step("pre7", 1'b1, 7, 32'h0000_1111, 1'b0, 0, 0);
    step("byp7", 1'b1, 7, 32'h0000_A5A5, 1'b1, 7, 7);
    check_eq("bypass_on", {16'h0000, r0a}, 32'h0000_A5A5);
    check_eq("bypass_off", r1a, 32'h0000_1111);
    step("aft7", 1'b0, 0, 32'h0, 1'b1, 7, 0);

    // Zero register, same cycle and next cycle.
    step("z0w", 1'b1, 0, 32'h0000_FFFF, 1'b1, 0, 0);
    check_eq("zero_same", {16'h0000, r0a}, 32'h0000_0000);
    step("z0r", 1'b0, 0, 32'h0, 1'b1, 0, 0);
    check_eq("zero_next", {16'h0000, r0a}, 32'h0000_0000);

    // Burst over r1..r4, then hold.
    for (int k = 1; k <= 4; k++) step("pre", 1'b1, k, 32'(k), 1'b0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step("burst", 1'b0, 0, 32'h0, 1'b1, k, k);
      check_eq("burst_val", {16'h0000, r0a}, 32'(k));
      check_eq("burst_v", {31'h0, r0v}, 32'h1);
    end
    step("hold", 1'b0, 0, 32'h0, 1'b0, 9, 9);
    check_eq("hold_val", {16'h0000, r0a}, 32'h4);
    check_eq("hold_v", {31'h0, r0v}, 32'h0);

    // Reset between edges, with a write and read coincident with reset.
    step("wr3", 1'b1, 3, 32'h0000_1234, 1'b1, 1, 2);
    #2 reset = 1'b1;
    #1;
    clear_model();
    check_all("rst_async");
    we = 1'b1; wa0 = 4'h3; wa1 = 3'h3; wd = 32'h0000_5555; re = 1'b1; ra0 = 4'h3; ra1 = 3'h3;
    @(posedge clk); #1;
    check_all("rst_edge");
    reset = 1'b0;
    step("rd3", 1'b0, 0, 32'h0, 1'b1, 3, 3);
    check_eq("rst_r3", {16'h0000, r0a}, 32'h0000_0000);

    // Randomised traffic, biased towards read/write address collisions.
    for (int n = 0; n < 400; n++) begin
      int a;
      int b;
      int w;
      w = int'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? w : int'($urandom_range(0, 15));
      b = ($urandom_range(0, 5) == 0) ? a : int'($urandom_range(0, 15));
      step("rnd", 1'($urandom_range(0, 1)), w, $urandom, 1'($urandom_range(0, 3) != 0), a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
